ps2_kbd_decoder: RTL and testbench

PS2_KBD_DECODER -- requirements
Module: ps2_kbd_decoder

---
 rtl/ps2_kbd_pkg.sv | 36 +++
 rtl/ps2_kbd_decoder_line_filter.sv | 40 ++++
 rtl/ps2_kbd_decoder.sv | 155 +++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, frame-state enum and byte classification for the PS/2 keyboard decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Keyboard control/status bytes that carry no key event.
  localparam logic [7:0] CTL_ACK    = 8'hFA;
  localparam logic [7:0] CTL_BAT_OK = 8'hAA;
  localparam logic [7:0] CTL_ECHO   = 8'hEE;
  localparam logic [7:0] CTL_RESEND = 8'hFE;
  localparam logic [7:0] CTL_ERR0   = 8'h00;
  localparam logic [7:0] CTL_ERR1   = 8'hFF;

  localparam int KEY_W           = 11;
  localparam int KEY_TOGGLE_BIT  = 10;
  localparam int KEY_PRESSED_BIT = 9;
  localparam int KEY_EXT_BIT     = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      PFX_PAUSE, CTL_ACK, CTL_BAT_OK, CTL_ECHO,
      CTL_RESEND, CTL_ERR0, CTL_ERR1: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_line_filter.sv
// Two-flop synchronizer followed by a deglitcher that only follows the input
// after FILT identical consecutive samples; idles high.
module ps2_line_filter #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]       sync_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: the synchronizer flops are reset to the idle-high line level so no
  // false falling edge is seen on the first cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard frame decoder producing toggle-flagged key events.
// Define PS2_KBD_WATCHDOG_EN to abort frames stalled for TIMEOUT_US.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 48000000,
  parameter int FILT       = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic              I_CLK_48M,
  input  logic              I_RESETn,
  input  logic              I_PS2_CLK,
  input  logic              I_PS2_DAT,
  output logic [KEY_W-1:0]  O_PS2_KEY,
  output logic              O_ERR
);

  logic fclk, fdat, fclk_prev_q, fall;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk    (I_CLK_48M),
    .rst_n  (I_RESETn),
    .line_i (I_PS2_CLK),
    .line_o (fclk)
  );

  ps2_line_filter #(.FILT(FILT)) u_dat_filt (
    .clk    (I_CLK_48M),
    .rst_n  (I_RESETn),
    .line_i (I_PS2_DAT),
    .line_o (fdat)
  );

  assign fall = fclk_prev_q & ~fclk;

  frame_state_e     state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             err_q, err_d;

`ifdef PS2_KBD_WATCHDOG_EN
  localparam int WD_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int WD_W      = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // NOTE: every always_comb output gets its hold/default value first so that
  // paths not assigning it cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    err_d     = 1'b0;

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!fdat) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {fdat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = fdat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (fdat && (^{shift_q, par_q})) begin
            if (shift_q == PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
              brk_d = 1'b1;
            end else if (!is_ignored(shift_q)) begin
              key_d[KEY_TOGGLE_BIT]  = ~key_q[KEY_TOGGLE_BIT];
              key_d[KEY_PRESSED_BIT] = ~brk_q;
              key_d[KEY_EXT_BIT]     = ext_q;
              key_d[7:0]             = shift_q;
              ext_d                  = 1'b0;
              brk_d                  = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef PS2_KBD_WATCHDOG_EN
    // Counting only without an edge makes a same-cycle edge win over expiry.
    wd_d = '0;
    if (!fall && state_q != IDLE) begin
      if (wd_q == WD_W'(WD_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      fclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      fclk_prev_q <= fclk;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      err_q       <= err_d;
    end
  end

`ifdef PS2_KBD_WATCHDOG_EN
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) wd_q <= '0;
    else           wd_q <= wd_d;
  end
`endif

  assign O_PS2_KEY = key_q;
  assign O_ERR     = err_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed self-checking bench for ps2_kbd_decoder (1 MHz model clock so the
// 2 ms watchdog spans 2000 cycles).
module tb_ps2_kbd_decoder;

  localparam int HALF = 20;  // PS/2 half bit period in system clocks
  localparam int FILT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] key;
  logic        err;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int err_cnt = 0;
  int evt_cnt = 0;
  int collide = 0;
  logic [10:0] key_prev = '0;

  ps2_kbd_decoder #(.CLK_HZ(1000000), .FILT(FILT), .TIMEOUT_US(2000)) dut (
    .I_CLK_48M (clk),
    .I_RESETn  (rst_n),
    .I_PS2_CLK (ps2_clk),
    .I_PS2_DAT (ps2_dat),
    .O_PS2_KEY (key),
    .O_ERR     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (key !== key_prev) evt_cnt++;
    if (err === 1'b1 && key !== key_prev) collide++;
    key_prev = key;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    err_cnt = 0;
    evt_cnt = 0;
    collide = 0;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit stop_bit = 1'b1, input int glitch_after = -1);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i]);
      if (i == glitch_after) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk_cnt++;
    if (key !== 11'h000) $display("FAIL reset_key_async: got %h exp %h", key, 11'h000);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (key !== 11'h000 || err !== 1'b0)
      $display("FAIL reset_outputs: key %h err %b exp 000 0", key, err);
    else pass_cnt++;
  endtask

  task automatic test_make_break();
    do_reset();
    send_frame(8'h29);
    chk_cnt++;
    if (key !== 11'h629) $display("FAIL make_29: got %h exp %h", key, 11'h629);
    else pass_cnt++;
    send_frame(8'hF0);
    chk_cnt++;
    if (key !== 11'h629) $display("FAIL brk_prefix_no_emit: got %h exp %h", key, 11'h629);
    else pass_cnt++;
    send_frame(8'h29);
    chk_cnt++;
    if (key !== 11'h029) $display("FAIL break_29: got %h exp %h", key, 11'h029);
    else pass_cnt++;
    chk_cnt++;
    if (err_cnt !== 0 || evt_cnt !== 2)
      $display("FAIL make_break_counts: err %0d evt %0d exp 0 2", err_cnt, evt_cnt);
    else pass_cnt++;
  endtask

  task automatic test_extended();
    do_reset();
    send_frame(8'hE0);
    chk_cnt++;
    if (key !== 11'h000) $display("FAIL ext_prefix_no_emit: got %h exp %h", key, 11'h000);
    else pass_cnt++;
    send_frame(8'h74);
    chk_cnt++;
    if (key !== 11'h774) $display("FAIL ext_make_74: got %h exp %h", key, 11'h774);
    else pass_cnt++;
    send_frame(8'hE0);
    send_frame(8'hF0);
    chk_cnt++;
    if (key !== 11'h774) $display("FAIL ext_brk_prefix_no_emit: got %h exp %h", key, 11'h774);
    else pass_cnt++;
    send_frame(8'h74);
    chk_cnt++;
    if (key !== 11'h174) $display("FAIL ext_break_74: got %h exp %h", key, 11'h174);
    else pass_cnt++;
    chk_cnt++;
    if (evt_cnt !== 2 || err_cnt !== 0)
      $display("FAIL ext_counts: evt %0d err %0d exp 2 0", evt_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_frame_errors();
    do_reset();
    send_frame(8'hE0);
    send_frame(8'h16, 1'b1);
    chk_cnt++;
    if (err_cnt !== 1 || key !== 11'h000)
      $display("FAIL parity_err: err %0d key %h exp 1 000", err_cnt, key);
    else pass_cnt++;
    send_frame(8'h16);
    chk_cnt++;
    if (key !== 11'h616) $display("FAIL after_parity_err_16: got %h exp %h", key, 11'h616);
    else pass_cnt++;
    send_frame(8'h16, 1'b0, 1'b0);
    chk_cnt++;
    if (err_cnt !== 2 || key !== 11'h616)
      $display("FAIL stop_err: err %0d key %h exp 2 616", err_cnt, key);
    else pass_cnt++;
    chk_cnt++;
    if (collide !== 0) $display("FAIL err_event_same_cycle: got %0d exp 0", collide);
    else pass_cnt++;
  endtask

  task automatic test_ignored();
    logic [7:0] ign [7];
    ign = '{8'hFA, 8'hAA, 8'hE1, 8'h00, 8'hFF, 8'hEE, 8'hFE};
    do_reset();
    send_frame(8'hF0);
    for (int i = 0; i < 7; i++) send_frame(ign[i]);
    chk_cnt++;
    if (evt_cnt !== 0 || key !== 11'h000)
      $display("FAIL ignored_no_emit: evt %0d key %h exp 0 000", evt_cnt, key);
    else pass_cnt++;
    send_frame(8'h1C);
    chk_cnt++;
    if (key !== 11'h41C) $display("FAIL ignored_keep_brk: got %h exp %h", key, 11'h41C);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [10:0] bits;
    int n;
    bit seen;
    do_reset();
    bits = {1'b1, ~^8'h29, 8'h29, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (key !== 11'h000) seen = 1'b1;
    end
    // 2 sync flops + FILT filter samples, then one cycle to the output register.
    chk_cnt++;
    if (!seen || n !== FILT + 3)
      $display("FAIL event_latency: got %0d cycles (seen %b) exp %0d", n, seen, FILT + 3);
    else pass_cnt++;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    chk_cnt++;
    if (key !== 11'h629) $display("FAIL latency_value: got %h exp %h", key, 11'h629);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    chk_cnt++;
    if (key !== 11'h61C || err_cnt !== 0)
      $display("FAIL glitch_1C: key %h err %0d exp 61C 0", key, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    do_reset();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (2500) @(negedge clk);
`ifdef PS2_KBD_WATCHDOG_EN
    chk_cnt++;
    if (err_cnt !== 1) $display("FAIL watchdog_pulse: got %0d exp 1", err_cnt);
    else pass_cnt++;
    send_frame(8'h1E);
`else
    chk_cnt++;
    if (err_cnt !== 0) $display("FAIL no_watchdog_pulse: got %0d exp 0", err_cnt);
    else pass_cnt++;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
`endif
    chk_cnt++;
    if (key !== 11'h61E) $display("FAIL after_timeout_1E: got %h exp %h", key, 11'h61E);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8'h29);
    chk_cnt++;
    if (key !== 11'h629) $display("FAIL pre_reset_29: got %h exp %h", key, 11'h629);
    else pass_cnt++;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    #3;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (key !== 11'h000 || err !== 1'b0)
      $display("FAIL midframe_reset: key %h err %b exp 000 0", key, err);
    else pass_cnt++;
    do_reset();
    send_frame(8'h05);
    chk_cnt++;
    if (key !== 11'h605 || err_cnt !== 0)
      $display("FAIL post_reset_05: key %h err %0d exp 605 0", key, err_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_frame_errors();
    test_ignored();
    test_latency();
    test_glitch();
    test_watchdog();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
